// File: rtl/trace_pkg_gen.sv
// trace_pkg_gen: captures per-instruction retire info from the writeback stage, packs it
// into a 256-bit trace package and buffers it in a small FIFO for the trace consumer.
// When the FIFO is full and nothing drains, the package is dropped: the drop is counted and
// the next accepted package carries a drop-before marker. The core is never stalled.
//
// Optional build macro: TRACE_PC_FILTER_EN adds filt_lo_i/filt_hi_i and captures only
// retires whose PC lies in [filt_lo_i, filt_hi_i] (unsigned, inclusive).
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   trace_en_i                 tracing enable (level)
//   retire_*_i                 writeback-stage retire information
//   filt_lo_i, filt_hi_i       PC filter window (TRACE_PC_FILTER_EN only)
//   pkg_ready_i                consumer accepts the head package
//   pkg_valid_o, pkg_o         FIFO head package
//   drop_cnt_o                 saturating dropped-package count
//   busy_o                     FIFO non-empty or not idle
module trace_pkg_gen #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEQ_W      = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          trace_en_i,
    input  logic          retire_valid_i,
    input  logic          retire_trap_i,
    input  logic [63:0]   retire_pc_i,
    input  logic [31:0]   retire_insn_i,
    input  logic          retire_rd_we_i,
    input  logic [4:0]    retire_rd_i,
    input  logic [63:0]   retire_rd_data_i,
    input  logic          retire_mem_rd_i,
    input  logic          retire_mem_wr_i,
    input  logic [63:0]   retire_mem_addr_i,
    input  logic [1:0]    retire_prv_i,
`ifdef TRACE_PC_FILTER_EN
    input  logic [63:0]   filt_lo_i,
    input  logic [63:0]   filt_hi_i,
`endif
    input  logic          pkg_ready_i,
    output logic          pkg_valid_o,
    output logic [255:0]  pkg_o,
    output logic [15:0]   drop_cnt_o,
    output logic          busy_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              drop_pend_q, drop_pend_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [255:0]      mem_q [FIFO_DEPTH];

    logic              pc_pass;
    logic              capture;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [255:0]      pkg_d;

`ifdef TRACE_PC_FILTER_EN
    // An inverted window (lo > hi) can never satisfy both bounds, so it filters everything.
    assign pc_pass = (retire_pc_i >= filt_lo_i) && (retire_pc_i <= filt_hi_i);
`else
    assign pc_pass = 1'b1;
`endif

    assign capture     = (state_q == StRun) && retire_valid_i && pc_pass;
    assign full        = (cnt_q == CntW'(FIFO_DEPTH));
    assign pkg_valid_o = (cnt_q != '0);
    assign pop         = pkg_valid_o && pkg_ready_i;
    // A same-cycle pop frees the slot, so a full FIFO still accepts.
    assign push        = capture && (!full || pop);
    assign drop        = capture && full && !pop;

    assign pkg_o      = pkg_valid_o ? mem_q[rd_ptr_q] : '0;
    assign drop_cnt_o = drop_cnt_q;
    assign busy_o     = pkg_valid_o || (state_q != StIdle);

    always_comb begin
        pkg_d            = '0;
        pkg_d[0+:64]     = retire_rd_we_i ? retire_rd_data_i : 64'd0;
        pkg_d[64+:64]    = (retire_mem_rd_i || retire_mem_wr_i) ? retire_mem_addr_i : 64'd0;
        pkg_d[128+:32]   = retire_insn_i;
        pkg_d[160+:64]   = retire_pc_i;
        pkg_d[224+:5]    = retire_rd_we_i ? retire_rd_i : 5'd0;
        pkg_d[229]       = retire_rd_we_i;
        pkg_d[230]       = retire_mem_rd_i;
        pkg_d[231]       = retire_mem_wr_i;
        pkg_d[232+:2]    = retire_prv_i;
        pkg_d[234+:SEQ_W] = seq_q;
        pkg_d[254]       = drop_pend_q;
        pkg_d[255]       = retire_trap_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trace_en_i) state_d = StRun;
            StRun:   if (!trace_en_i) state_d = StFlush;
            StFlush: begin
                if (trace_en_i) begin
                    state_d = StRun;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        seq_d       = seq_q;
        drop_pend_d = drop_pend_q;
        drop_cnt_d  = drop_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        // Sequence restarts on every new trace session; dropped retires still consume a number.
        if ((state_q == StIdle) && trace_en_i) begin
            seq_d = '0;
        end else if (capture) begin
            seq_d = seq_q + 1'b1;
        end

        if (drop) begin
            drop_pend_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (push) begin
            drop_pend_d = 1'b0;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            seq_q       <= '0;
            drop_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            drop_pend_q <= drop_pend_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset: the output is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkg_d;
        end
    end

endmodule

// File: tb/tb_trace_pkg_gen.sv
module tb_trace_pkg_gen;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trace_en = 1'b0;
    logic         rv = 1'b0;
    logic         trap = 1'b0;
    logic [63:0]  pc = '0;
    logic [31:0]  insn = '0;
    logic         rd_we = 1'b0;
    logic [4:0]   rd = '0;
    logic [63:0]  rd_data = '0;
    logic         mem_rd = 1'b0;
    logic         mem_wr = 1'b0;
    logic [63:0]  mem_addr = '0;
    logic [1:0]   prv = '0;
    logic         ready = 1'b1;
`ifdef TRACE_PC_FILTER_EN
    logic [63:0]  filt_lo = '0;
    logic [63:0]  filt_hi = '1;
`endif
    logic         pkg_valid;
    logic [255:0] pkg;
    logic [15:0]  drop_cnt;
    logic         busy;

    trace_pkg_gen #(.FIFO_DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .trace_en_i        (trace_en),
        .retire_valid_i    (rv),
        .retire_trap_i     (trap),
        .retire_pc_i       (pc),
        .retire_insn_i     (insn),
        .retire_rd_we_i    (rd_we),
        .retire_rd_i       (rd),
        .retire_rd_data_i  (rd_data),
        .retire_mem_rd_i   (mem_rd),
        .retire_mem_wr_i   (mem_wr),
        .retire_mem_addr_i (mem_addr),
        .retire_prv_i      (prv),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo_i         (filt_lo),
        .filt_hi_i         (filt_hi),
`endif
        .pkg_ready_i       (ready),
        .pkg_valid_o       (pkg_valid),
        .pkg_o             (pkg),
        .drop_cnt_o        (drop_cnt),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: a queue of packages plus session bookkeeping (0 idle, 1 run, 2 flush).
    logic [255:0] mq[$];
    int           m_mode;
    int           m_seq;
    bit           m_pend;
    int           m_drops;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic bit filt_ok();
`ifdef TRACE_PC_FILTER_EN
        return (pc >= filt_lo) && (pc <= filt_hi);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [255:0] build(input int seq, input bit flag);
        logic [255:0] p;
        p = '0;
        p[63:0]    = rd_we ? rd_data : 64'd0;
        p[127:64]  = (mem_rd || mem_wr) ? mem_addr : 64'd0;
        p[159:128] = insn;
        p[223:160] = pc;
        p[228:224] = rd_we ? rd : 5'd0;
        p[229]     = rd_we;
        p[230]     = mem_rd;
        p[231]     = mem_wr;
        p[233:232] = prv;
        p[249:234] = 16'(seq);
        p[254]     = flag;
        p[255]     = trap;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_seq   = 0;
        m_pend  = 0;
        m_drops = 0;
    endtask

    task automatic model_step();
        int  sz;
        bit  pop;
        sz  = mq.size();
        pop = (sz > 0) && ready;
        if (m_mode == 1 && rv && filt_ok()) begin
            if (sz < DEPTH || pop) begin
                mq.push_back(build(m_seq, m_pend));
                m_pend = 0;
            end else begin
                m_pend = 1;
                if (m_drops < 65535) m_drops++;
            end
            m_seq = (m_seq + 1) % 65536;
        end
        if (pop) void'(mq.pop_front());
        case (m_mode)
            0: if (trace_en) begin m_mode = 1; m_seq = 0; end
            1: if (!trace_en) m_mode = 2;
            default: if (trace_en) m_mode = 1; else if (sz == 0) m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        logic [255:0] exp_pkg;
        exp_pkg = (mq.size() > 0) ? mq[0] : '0;
        chk("pkg_valid", {255'd0, pkg_valid}, {255'd0, mq.size() > 0});
        chk("pkg", pkg, exp_pkg);
        chk("drop_cnt", {240'd0, drop_cnt}, 256'(m_drops));
        chk("busy", {255'd0, busy}, {255'd0, (mq.size() > 0) || (m_mode != 0)});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pkg_valid", {255'd0, pkg_valid}, '0);
        chk("rst_drop_cnt", {240'd0, drop_cnt}, '0);
        chk("rst_busy", {255'd0, busy}, '0);
        chk("rst_pkg", pkg, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_fields();
        trap     = ($urandom_range(0, 7) == 0);
        pc       = {$urandom, $urandom};
        insn     = $urandom;
        rd_we    = $urandom_range(0, 1);
        rd       = 5'($urandom);
        rd_data  = {$urandom, $urandom};
        mem_rd   = $urandom_range(0, 1);
        mem_wr   = !mem_rd && ($urandom_range(0, 1) == 1);
        mem_addr = {$urandom, $urandom};
        prv      = 2'($urandom);
    endtask

    task automatic drain_to_idle();
        trace_en = 1'b0;
        rv       = 1'b0;
        ready    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy) break;
        end
        chk("drain_idle", {255'd0, busy}, '0);
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        rd_we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        mr;
        logic        mw;
        logic [63:0] addr;
        logic [1:0]  prv;
        logic        trap;
        logic [63:0] e_data;
        logic [63:0] e_addr;
        logic [4:0]  e_rd;
        logic [15:0] e_seq;
        logic [7:0]  e_flags;   // {trap, drop, 0,0,0, mem_wr, mem_rd, rd_we}
    } vec_t;

    vec_t vecs[5];
    logic [15:0] seqs[$];
    bit          flags[$];
    int          npop;

    initial begin
        vecs[0] = '{64'h8000_0000, 32'h0050_0293, 1, 5'd5, 64'h1234, 0, 0, 64'h0, 2'd3, 0,
                    64'h1234, 64'h0, 5'd5, 16'd0, 8'h01};
        vecs[1] = '{64'h8000_0004, 32'h0000_0073, 1, 5'd7, 64'hABCD, 0, 0, 64'h0, 2'd0, 1,
                    64'hABCD, 64'h0, 5'd7, 16'd1, 8'h81};
        vecs[2] = '{64'h8000_0008, 32'h00A2_3023, 0, 5'd9, 64'hDEAD, 0, 1, 64'h1000_0040, 2'd1, 0,
                    64'h0, 64'h1000_0040, 5'd0, 16'd2, 8'h04};
        vecs[3] = '{64'h8000_000C, 32'h0002_BF83, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0,
                    64'h2000, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2000, 5'd31, 16'd3, 8'h03};
        vecs[4] = '{64'h8000_0010, 32'h0000_0013, 0, 5'd3, 64'h77, 0, 0, 64'h5555, 2'd2, 0,
                    64'h0, 64'h0, 5'd0, 16'd4, 8'h00};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        compare_all();

        // Table-driven single retires with the consumer always ready.
        trace_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            pc = vecs[i].pc; insn = vecs[i].insn; rd_we = vecs[i].rd_we; rd = vecs[i].rd;
            rd_data = vecs[i].data; mem_rd = vecs[i].mr; mem_wr = vecs[i].mw;
            mem_addr = vecs[i].addr; prv = vecs[i].prv; trap = vecs[i].trap;
            rv = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), {255'd0, pkg_valid}, 256'd1);
            chk($sformatf("vec%0d_data", i), {192'd0, pkg[0+:64]}, {192'd0, vecs[i].e_data});
            chk($sformatf("vec%0d_addr", i), {192'd0, pkg[64+:64]}, {192'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_pc", i), {192'd0, pkg[160+:64]}, {192'd0, vecs[i].pc});
            chk($sformatf("vec%0d_rd", i), {251'd0, pkg[224+:5]}, {251'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d_seq", i), {240'd0, pkg[234+:16]}, {240'd0, vecs[i].e_seq});
            chk($sformatf("vec%0d_flags", i),
                {248'd0, pkg[255], pkg[254], 3'b000, pkg[231], pkg[230], pkg[229]},
                {248'd0, vecs[i].e_flags});
        end
        rv = 1'b0;
        drain_to_idle();

        // Overflow with a stalled consumer, then full-FIFO push with a same-cycle pop.
        trace_en = 1'b1;
        step();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_fields(); rv = 1'b1; step();
        end
        rv = 1'b0;
        chk("ovf_drop_cnt", {240'd0, drop_cnt}, 256'd2);
        seqs.delete(); flags.delete();
        seqs.push_back(pkg[234+:16]); flags.push_back(pkg[254]);
        ready = 1'b1;
        rand_fields(); rv = 1'b1; step(); rv = 1'b0;
        chk("full_pop_no_drop", {240'd0, drop_cnt}, 256'd2);
        seqs.push_back(pkg[234+:16]); flags.push_back(pkg[254]);
        for (int i = 0; i < 3; i++) begin
            step();
            seqs.push_back(pkg[234+:16]); flags.push_back(pkg[254]);
        end
        chk("ovf_seq0", 256'(seqs[0]), 256'd0);
        chk("ovf_seq1", 256'(seqs[1]), 256'd1);
        chk("ovf_seq2", 256'(seqs[2]), 256'd2);
        chk("ovf_seq3", 256'(seqs[3]), 256'd3);
        chk("ovf_seq4", 256'(seqs[4]), 256'd6);
        chk("ovf_flags", 256'({flags[0], flags[1], flags[2], flags[3], flags[4]}), 256'b00001);
        step();
        rand_fields(); rv = 1'b1; step(); rv = 1'b0;
        chk("after_mark_seq", {240'd0, pkg[234+:16]}, 256'd7);
        chk("after_mark_flag", {255'd0, pkg[254]}, 256'd0);
        step();

        // Disable with three packages queued: flush ignores retires and drains them.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(); rv = 1'b1; step();
        end
        rv = 1'b0; trace_en = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_fields(); rv = 1'b1; step();
            chk("flush_busy", {255'd0, busy}, 256'd1);
        end
        ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            if (pkg_valid) npop++;
            rand_fields(); step();
        end
        rv = 1'b0;
        chk("flush_pops", 256'(npop), 256'd3);
        chk("flush_idle", {255'd0, busy}, 256'd0);
        trace_en = 1'b1;
        step();
        rand_fields(); rv = 1'b1; step(); rv = 1'b0;
        chk("reenable_seq", {240'd0, pkg[234+:16]}, 256'd0);
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            trace_en = ($urandom_range(0, 15) != 0);
            ready    = ($urandom_range(0, 3) != 0);
            rv       = $urandom_range(0, 1);
            rand_fields();
            step();
        end

        // Reset asserted in the middle of an overflowing burst.
        trace_en = 1'b1; ready = 1'b0; rv = 1'b0;
        step(); step();
        for (int i = 0; i < 6; i++) begin
            rand_fields(); rv = 1'b1; step();
        end
        do_reset();
        rv = 1'b0;
        compare_all();
        step();

`ifdef TRACE_PC_FILTER_EN
        drain_to_idle();
        filt_lo = 64'h100; filt_hi = 64'h1FF;
        trace_en = 1'b1; ready = 1'b1;
        step();
        seqs.delete();
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            case (i)
                0: pc = 64'hFC;
                1: pc = 64'h100;
                2: pc = 64'h1FF;
                default: pc = 64'h200;
            endcase
            rv = 1'b1; step();
            if (pkg_valid) seqs.push_back(pkg[234+:16]);
            if (pkg_valid) chk("filt_pc", {192'd0, pkg[160+:64]}, (i == 1) ? 256'h100 : 256'h1FF);
        end
        rv = 1'b0;
        chk("filt_count", 256'(seqs.size()), 256'd2);
        chk("filt_drop_cnt", {240'd0, drop_cnt}, 256'd0);
        step();
        filt_lo = 64'h200; filt_hi = 64'h100;
        for (int i = 0; i < 4; i++) begin
            rand_fields(); pc = 64'h180; rv = 1'b1; step();
            chk("filt_inverted", {255'd0, pkg_valid}, 256'd0);
        end
        rv = 1'b0;
        filt_lo = '0; filt_hi = '1;
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
